micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
  DATAWIDTH_ADDRESS, 11, control-store address width
  DATAWIDTH_DECODEROP, 8, opcode field width, with DATAWIDTH_ADDRESS >= DATAWIDTH_DECODEROP+1
  DATAWIDTH_COND, 4, microbranch condition code width
  DATAWIDTH_PSR, 4, flag register width {N,Z,V,C}
  STACK_DEPTH, 4, microsubroutine return-stack entries, with STACK_DEPTH >= 1
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
  MICRO_SEQUENCER_CLOCK_50  in  1  system clock
  MICRO_SEQUENCER_ResetInHigh_In  in  1  synchronous active-high reset
  MICRO_SEQUENCER_WaitAck_In  in  1  current microword is a memory access
  MICRO_SEQUENCER_ACK_In  in  1  memory acknowledge
  MICRO_SEQUENCER_Condition_InBus  in  DATAWIDTH_COND  COND field of the MIR
  MICRO_SEQUENCER_JumpAddress_InBus  in  DATAWIDTH_ADDRESS  JUMP field of the MIR
  MICRO_SEQUENCER_DecodeOp_InBus  in  DATAWIDTH_DECODEROP  opcode bits from the IR
  MICRO_SEQUENCER_IR13_In  in  1  IR bit 13
  MICRO_SEQUENCER_FlagNegative_In / FlagZero_In / FlagOverflow_In / FlagCarry_In  in  1 each  ALU flags
  MICRO_SEQUENCER_SetCodes_In  in  1  load the PSR from the ALU flags
  MICRO_SEQUENCER_CSAddress_OutBus  out  DATAWIDTH_ADDRESS  registered control-store address
  MICRO_SEQUENCER_Psr_OutBus  out  DATAWIDTH_PSR  registered {N,Z,V,C}
  MICRO_SEQUENCER_StackOverflow_Out  out  1  sticky error flag
  MICRO_SEQUENCER_StackUnderflow_Out  out  1  sticky error flag

Function
REQ-004 CSAddress SHALL be a register, updated on each rising clock edge with the next address selected from the current Condition, and the current address SHALL drive the microcode store.
REQ-005 Next-address selection by Condition SHALL be:
  0: CSAddress+1
  1-4: JumpAddress if the PSR bit N, Z, V or C respectively is 1, else CSAddress+1
  5: JumpAddress if IR13=1, else CSAddress+1
  6: JumpAddress unconditionally
  7: decode address
  8: CALL
  9: RET
  10: JumpAddress if Z=0, else CSAddress+1
  11-15: treated as 0
REQ-006 The decode address SHALL be {1'b1, DecodeOp, (DATAWIDTH_ADDRESS-DATAWIDTH_DECODEROP-1) zero bits}; at the default widths this is {1,op,00}.
REQ-007 CSAddress+1 SHALL be computed modulo 2^DATAWIDTH_ADDRESS, so all-ones wraps to 0.
REQ-008 Branch conditions SHALL use the registered PSR value; when SetCodes and a flag branch occur in the same cycle, the pre-update PSR SHALL be used.
REQ-009 The PSR SHALL load {N,Z,V,C} on an edge where SetCodes=1 and there is no stall, and SHALL hold otherwise.
REQ-010 Stall SHALL be defined as WaitAck=1 and ACK=0; during a stall, CSAddress, the PSR, the stack and the error flags SHALL all hold.
REQ-011 When WaitAck=1 and ACK=1, the sequencer SHALL advance normally in that cycle.
REQ-012 When WaitAck=0, ACK SHALL be ignored.
REQ-013 CALL SHALL push CSAddress+1 (wrapped) onto the stack, increment the stack pointer and jump to JumpAddress, so single-cycle latency applies.
REQ-014 RET SHALL pop the top entry into CSAddress and decrement the stack pointer.
REQ-015 The stack SHALL be LIFO, with a pointer range of 0..STACK_DEPTH, where 0 means empty.
REQ-016 CALL with the stack full SHALL still jump to JumpAddress, but SHALL not push and SHALL leave the pointer unchanged; StackOverflow SHALL be set to 1.
REQ-017 RET with the stack empty SHALL go to CSAddress+1 and leave the pointer unchanged; StackUnderflow SHALL be set to 1.
REQ-018 StackOverflow and StackUnderflow SHALL be sticky and SHALL clear only on reset.
REQ-019 Nested CALLs up to STACK_DEPTH deep SHALL return in reverse order with no loss.

Reset
REQ-020 While ResetInHigh is sampled 1 at a clock edge, CSAddress SHALL become 0, the PSR 0, the stack pointer 0 and both error flags 0; stack contents need not be cleared.
REQ-021 Reset SHALL override stall, CALL, RET and SetCodes in the same cycle.
REQ-022 Reset asserted mid-subroutine SHALL discard all pending return addresses.
REQ-023 The first non-reset edge SHALL move CSAddress according to the Condition presented at address 0.

Verification
REQ-024 Reset, then Cond=0 for 3 cycles -> CSAddress sequence 0,1,2,3; with CSAddress=0x7FF and Cond=0 -> next is 0x000.
REQ-025 SetCodes=1 with Z=1 and Cond=2 in the same cycle -> CSAddress+1, because the old PSR is used; the next cycle with Cond=2 and Jump=0x123 -> 0x123; Psr=0b0100.
REQ-026 DecodeOp=0xC4 and Cond=7 -> CSAddress=0x710.
REQ-027 CALL 0x100 from 0x010, then CALL 0x200 from 0x101, then RET, RET -> address sequence 0x100, 0x200, 0x102, 0x011; no error flags set.
REQ-028 Five CALLs with STACK_DEPTH=4 -> StackOverflow=1 and the fifth jump is taken; then five RETs -> the first four return correctly, the fifth sets StackUnderflow=1 and goes to CSAddress+1.
REQ-029 WaitAck=1 and ACK=0 for 3 cycles with Cond=6 and SetCodes=1 -> CSAddress and PSR unchanged; ACK=1 -> jump taken and PSR loaded; reset during a stall -> CSAddress=0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered control-store address, flag register,
// bounded microsubroutine return stack with sticky overflow/underflow flags.
module micro_sequencer #(
  parameter int DATAWIDTH_ADDRESS   = 11,
  parameter int DATAWIDTH_DECODEROP = 8,
  parameter int DATAWIDTH_COND      = 4,
  parameter int DATAWIDTH_PSR       = 4,
  parameter int STACK_DEPTH         = 4
) (
  input  logic                           MICRO_SEQUENCER_CLOCK_50,
  input  logic                           MICRO_SEQUENCER_ResetInHigh_In,
  input  logic                           MICRO_SEQUENCER_WaitAck_In,
  input  logic                           MICRO_SEQUENCER_ACK_In,
  input  logic [DATAWIDTH_COND-1:0]      MICRO_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_ADDRESS-1:0]   MICRO_SEQUENCER_JumpAddress_InBus,
  input  logic [DATAWIDTH_DECODEROP-1:0] MICRO_SEQUENCER_DecodeOp_InBus,
  input  logic                           MICRO_SEQUENCER_IR13_In,
  input  logic                           MICRO_SEQUENCER_FlagNegative_In,
  input  logic                           MICRO_SEQUENCER_FlagZero_In,
  input  logic                           MICRO_SEQUENCER_FlagOverflow_In,
  input  logic                           MICRO_SEQUENCER_FlagCarry_In,
  input  logic                           MICRO_SEQUENCER_SetCodes_In,
  output logic [DATAWIDTH_ADDRESS-1:0]   MICRO_SEQUENCER_CSAddress_OutBus,
  output logic [DATAWIDTH_PSR-1:0]       MICRO_SEQUENCER_Psr_OutBus,
  output logic                           MICRO_SEQUENCER_StackOverflow_Out,
  output logic                           MICRO_SEQUENCER_StackUnderflow_Out
);

  localparam int AW    = DATAWIDTH_ADDRESS;
  localparam int OW    = DATAWIDTH_DECODEROP;
  localparam int PW    = DATAWIDTH_PSR;
  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SPW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [DATAWIDTH_COND-1:0] {
    COND_NEXT   = 0,
    COND_N      = 1,
    COND_Z      = 2,
    COND_V      = 3,
    COND_C      = 4,
    COND_IR13   = 5,
    COND_JUMP   = 6,
    COND_DECODE = 7,
    COND_CALL   = 8,
    COND_RET    = 9,
    COND_NZ     = 10
  } cond_e;

  cond_e          cond;
  logic           stall;
  logic [AW-1:0]  cs_q, cs_d, cs_inc, decode_addr;
  logic [PW-1:0]  psr_q, psr_d;
  logic [SPW-1:0] sp_q, sp_d, sp_dec;
  logic [AW-1:0]  stack_q [SLOTS];
  logic [AW-1:0]  stack_d [SLOTS];
  logic           ovf_q, ovf_d, unf_q, unf_d;

  assign cond        = cond_e'(MICRO_SEQUENCER_Condition_InBus);
  assign stall       = MICRO_SEQUENCER_WaitAck_In & ~MICRO_SEQUENCER_ACK_In;
  assign cs_inc      = cs_q + AW'(1);
  assign sp_dec      = sp_q - SPW'(1);
  // Opcode lands just below the MSB; the low bits give each opcode a small routine slot.
  assign decode_addr = AW'({1'b1, MICRO_SEQUENCER_DecodeOp_InBus}) << (AW - OW - 1);

  always_comb begin
    cs_d    = cs_q;
    psr_d   = psr_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!stall) begin
      if (MICRO_SEQUENCER_SetCodes_In)
        psr_d = PW'({MICRO_SEQUENCER_FlagNegative_In, MICRO_SEQUENCER_FlagZero_In,
                     MICRO_SEQUENCER_FlagOverflow_In, MICRO_SEQUENCER_FlagCarry_In});
      case (cond)
        COND_N:      cs_d = psr_q[3] ? MICRO_SEQUENCER_JumpAddress_InBus : cs_inc;
        COND_Z:      cs_d = psr_q[2] ? MICRO_SEQUENCER_JumpAddress_InBus : cs_inc;
        COND_V:      cs_d = psr_q[1] ? MICRO_SEQUENCER_JumpAddress_InBus : cs_inc;
        COND_C:      cs_d = psr_q[0] ? MICRO_SEQUENCER_JumpAddress_InBus : cs_inc;
        COND_IR13:   cs_d = MICRO_SEQUENCER_IR13_In ? MICRO_SEQUENCER_JumpAddress_InBus : cs_inc;
        COND_JUMP:   cs_d = MICRO_SEQUENCER_JumpAddress_InBus;
        COND_DECODE: cs_d = decode_addr;
        COND_NZ:     cs_d = psr_q[2] ? cs_inc : MICRO_SEQUENCER_JumpAddress_InBus;
        COND_CALL: begin
          cs_d = MICRO_SEQUENCER_JumpAddress_InBus;
          if (sp_q == SP_FULL) begin
            ovf_d = 1'b1;
          end else begin
            stack_d[sp_q] = cs_inc;
            sp_d          = sp_q + SPW'(1);
          end
        end
        COND_RET: begin
          if (sp_q == '0) begin
            cs_d  = cs_inc;
            unf_d = 1'b1;
          end else begin
            cs_d = stack_q[sp_dec];
            sp_d = sp_dec;
          end
        end
        default:     cs_d = cs_inc;
      endcase
    end
  end

  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (MICRO_SEQUENCER_ResetInHigh_In) begin
      cs_q  <= '0;
      psr_q <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cs_q  <= cs_d;
      psr_q <= psr_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
    // Contents are don't-care once the pointer is cleared.
    stack_q <= stack_d;
  end

  assign MICRO_SEQUENCER_CSAddress_OutBus   = cs_q;
  assign MICRO_SEQUENCER_Psr_OutBus         = psr_q;
  assign MICRO_SEQUENCER_StackOverflow_Out  = ovf_q;
  assign MICRO_SEQUENCER_StackUnderflow_Out = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed and randomized checks of micro_sequencer against a queue-based
// reference model of the sequencing rules.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0, wait_ack = 1'b0, ack = 1'b0, ir13 = 1'b0;
  logic        fn = 1'b0, fz = 1'b0, fv = 1'b0, fc = 1'b0, setc = 1'b0;
  logic [3:0]  cond = '0;
  logic [10:0] jump = '0;
  logic [7:0]  op = '0;
  logic [10:0] cs;
  logic [3:0]  psr;
  logic        ovf, unf;

  int compared = 0;
  int failed   = 0;

  int m_cs = 0, m_psr = 0;
  int m_stk[$];
  int m_ovf = 0, m_unf = 0;

  micro_sequencer dut (
    .MICRO_SEQUENCER_CLOCK_50           (clk),
    .MICRO_SEQUENCER_ResetInHigh_In     (rst),
    .MICRO_SEQUENCER_WaitAck_In         (wait_ack),
    .MICRO_SEQUENCER_ACK_In             (ack),
    .MICRO_SEQUENCER_Condition_InBus    (cond),
    .MICRO_SEQUENCER_JumpAddress_InBus  (jump),
    .MICRO_SEQUENCER_DecodeOp_InBus     (op),
    .MICRO_SEQUENCER_IR13_In            (ir13),
    .MICRO_SEQUENCER_FlagNegative_In    (fn),
    .MICRO_SEQUENCER_FlagZero_In        (fz),
    .MICRO_SEQUENCER_FlagOverflow_In    (fv),
    .MICRO_SEQUENCER_FlagCarry_In       (fc),
    .MICRO_SEQUENCER_SetCodes_In        (setc),
    .MICRO_SEQUENCER_CSAddress_OutBus   (cs),
    .MICRO_SEQUENCER_Psr_OutBus         (psr),
    .MICRO_SEQUENCER_StackOverflow_Out  (ovf),
    .MICRO_SEQUENCER_StackUnderflow_Out (unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the next address and side effects follow directly from the condition table.
  task automatic model_edge(input int c, input int j, input int o, input int ir,
                            input int flags, input int sc, input int w, input int a, input int r);
    int inc, nxt;
    if (r != 0) begin
      m_cs = 0; m_psr = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
      return;
    end
    if (w != 0 && a == 0) return;
    inc = (m_cs + 1) % 2048;
    nxt = inc;
    if (c >= 1 && c <= 4) nxt = ((m_psr >> (4 - c)) & 1) ? j : inc;
    else if (c == 5) nxt = ir ? j : inc;
    else if (c == 6) nxt = j;
    else if (c == 7) nxt = 1024 + o * 4;
    else if (c == 8) begin
      nxt = j;
      if (m_stk.size() < 4) m_stk.push_back(inc);
      else m_ovf = 1;
    end else if (c == 9) begin
      if (m_stk.size() > 0) nxt = m_stk.pop_back();
      else m_unf = 1;
    end else if (c == 10) nxt = ((m_psr >> 2) & 1) ? inc : j;
    if (sc != 0) m_psr = flags;
    m_cs = nxt;
  endtask

  task automatic step(input string tag, input int c, input int j, input int o = 0,
                      input int ir = 0, input int flags = 0, input int sc = 0,
                      input int w = 0, input int a = 0, input int r = 0);
    cond = 4'(c); jump = 11'(j); op = 8'(o); ir13 = (ir != 0);
    fn = flags[3]; fz = flags[2]; fv = flags[1]; fc = flags[0];
    setc = (sc != 0); wait_ack = (w != 0); ack = (a != 0); rst = (r != 0);
    model_edge(c, j, o, ir, flags, sc, w, a, r);
    @(posedge clk);
    #1;
    check({tag, " cs"},  32'(cs),  32'(m_cs));
    check({tag, " psr"}, 32'(psr), 32'(m_psr));
    check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, " unf"}, 32'(unf), 32'(m_unf));
  endtask

  initial begin
    @(posedge clk); #1;

    step("reset", 0, 0, .r(1));
    check("reset cs lit", 32'(cs), 32'h0);
    step("inc1", 0, 0);
    step("inc2", 0, 0);
    step("inc3", 0, 0);
    check("inc3 lit", 32'(cs), 32'h3);
    step("jmp7ff", 6, 11'h7FF);
    step("wrap", 0, 0);
    check("wrap lit", 32'(cs), 32'h0);

    step("reset2", 0, 0, .r(1));
    step("oldpsr", 2, 11'h123, .flags(4'b0100), .sc(1));
    check("oldpsr lit", 32'(cs), 32'h1);
    step("newpsr", 2, 11'h123);
    check("newpsr lit", 32'(cs), 32'h123);
    check("psr lit", 32'(psr), 32'h4);
    step("nz_notaken", 10, 11'h055);
    step("decode", 7, 0, .o(8'hC4));
    check("decode lit", 32'(cs), 32'h710);

    step("reset3", 0, 0, .r(1));
    step("to010", 6, 11'h010);
    step("call100", 8, 11'h100);
    step("inc101", 0, 0);
    step("call200", 8, 11'h200);
    step("ret1", 9, 0);
    check("ret1 lit", 32'(cs), 32'h102);
    step("ret2", 9, 0);
    check("ret2 lit", 32'(cs), 32'h011);

    step("reset4", 0, 0, .r(1));
    for (int i = 1; i <= 5; i++) step("callN", 8, i * 256);
    check("ovf lit", 32'(ovf), 32'h1);
    check("call5 lit", 32'(cs), 32'h500);
    for (int i = 1; i <= 5; i++) step("retN", 9, 0);
    check("unf lit", 32'(unf), 32'h1);
    check("ret5 lit", 32'(cs), 32'h002);

    step("reset5", 0, 0, .r(1));
    for (int i = 0; i < 3; i++) step("stall", 6, 11'h3AA, .flags(4'b1010), .sc(1), .w(1), .a(0));
    check("stall lit", 32'(cs), 32'h0);
    step("ackgo", 6, 11'h3AA, .flags(4'b1010), .sc(1), .w(1), .a(1));
    check("ackgo lit", 32'(cs), 32'h3AA);
    check("ackpsr lit", 32'(psr), 32'hA);
    step("nowait_noack", 0, 0, .w(0), .a(0));
    step("rst_in_stall", 9, 0, .w(1), .a(0), .r(1));
    check("rst_stall lit", 32'(cs), 32'h0);

    for (int i = 0; i < 400; i++) begin
      int c, w;
      c = $urandom_range(0, 15);
      if (c > 10 && $urandom_range(0, 1) == 0) c = $urandom_range(8, 9);
      w = ($urandom_range(0, 3) == 0);
      step("rand", c, $urandom_range(0, 2047), $urandom_range(0, 255), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1), w, $urandom_range(0, 1),
           ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
